// File: rtl/hdc_pkg.sv
// Shared constants, types and helpers for the RC-HDC classifier front end.
package hdc_pkg;

    localparam int DIM      = 16;
    localparam int SMP_SIZE = 4;
    localparam int LEVELS   = 4;

    typedef logic [DIM-1:0] hv_t;

    typedef enum logic {IDLE, RUN} feed_st_e;

    function automatic hv_t rotl1(input hv_t v);
        return {v[DIM-2:0], v[DIM-1]};
    endfunction

endpackage

// File: rtl/level_mask_gen.sv
// Combinational thermometer mask: the low v*STEP bits are set, where v is the
// feature value clamped to LEVELS-1.
module level_mask_gen #(
    parameter int DIM    = 16,
    parameter int LEVELS = 16,
    parameter int VAL_W  = $clog2(LEVELS)
) (
    input  logic [VAL_W-1:0] value,
    output logic [DIM-1:0]   mask
);

    // Floor keeps the top level at or below DIM/2 flipped bits.
    localparam int STEP = DIM / (2 * (LEVELS - 1));

    int v_clamped;
    int nflip;

    always_comb begin
        v_clamped = (int'(value) > LEVELS - 1) ? LEVELS - 1 : int'(value);
        nflip     = v_clamped * STEP;
        mask      = '0;
        for (int i = 0; i < DIM; i++) begin
            mask[i] = (i < nflip);
        end
    end

endmodule

// File: rtl/hv_feeder.sv
// Feature feeder: turns a valid/ready feature stream into registered
// position/level hypervector pairs for the spatial encoder.
module hv_feeder
    import hdc_pkg::*;
#(
    parameter int  VAL_W    = $clog2(LEVELS),
    parameter hv_t POS_SEED = hv_t'('hA5A5),
    parameter hv_t LVL_BASE = hv_t'('h3C3C)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             feat_valid,
    output logic             feat_ready,
    input  logic [VAL_W-1:0] feat_value,
    input  logic             feat_last,
    output hv_t              im_value,
    output hv_t              im_pos,
    output logic             smp_en,
    output logic             smp_last,
    output logic             busy,
    output logic             err
);

    // Handshake: a feature transfers in any cycle where feat_valid and
    // feat_ready are both high; feat_ready never depends on feat_valid.

    localparam int IDX_W = $clog2(SMP_SIZE + 1);

    feed_st_e   state;
    feed_st_e   state_next;
    logic [IDX_W-1:0] idx;
    hv_t        pos_hv;
    hv_t        lvl_mask;
    logic       acc;
    logic       is_last_idx;

    assign feat_ready  = (state == RUN) && !abort;
    assign acc         = feat_valid && feat_ready;
    assign is_last_idx = (idx == IDX_W'(SMP_SIZE - 1));
    assign busy        = (state == RUN);

    level_mask_gen #(
        .DIM    (DIM),
        .LEVELS (LEVELS),
        .VAL_W  (VAL_W)
    ) u_mask (
        .value (feat_value),
        .mask  (lvl_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && !abort) state_next = RUN;
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (acc && is_last_idx) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            pos_hv   <= POS_SEED;
            im_value <= '0;
            im_pos   <= '0;
            smp_en   <= 1'b0;
            smp_last <= 1'b0;
            err      <= 1'b0;
        end else begin
            smp_en   <= acc;
            smp_last <= acc && is_last_idx;
            if (acc) begin
                im_pos   <= pos_hv;
                im_value <= LVL_BASE ^ lvl_mask;
            end
            if (abort || (state == IDLE && start)) begin
                idx    <= '0;
                pos_hv <= POS_SEED;
                err    <= 1'b0;
            end else if (acc) begin
                // The count ends the sample; feat_last only flags disagreement.
                if (feat_last != is_last_idx) err <= 1'b1;
                if (is_last_idx) begin
                    idx    <= '0;
                    pos_hv <= POS_SEED;
                end else begin
                    idx    <= idx + 1'b1;
                    pos_hv <= rotl1(pos_hv);
                end
            end
        end
    end

endmodule
